// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the unified memory.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata;
  logic          ext_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          grant_id;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, grant_id
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / external loader) arbiter for the unified MIPS memory with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed ext-over-CPU priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          gid_q, gid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic          pick_ext;
  logic          cpu_ack;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  // On a tie the port that did not win last time gets the memory.
  assign pick_ext = bus.ext_req & (~bus.cpu_req | ~last_q);
`else
  assign pick_ext = bus.ext_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      gid_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      gid_q       <= gid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    gid_d       = gid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cpu_req | bus.ext_req) begin
          gid_d   = pick_ext;
          we_d    = pick_ext ? bus.ext_we    : bus.cpu_we;
          addr_d  = pick_ext ? bus.ext_addr  : bus.cpu_addr;
          wdata_d = pick_ext ? bus.ext_wdata : bus.cpu_wdata;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_ext;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (gid_q) ext_rdata_d = bus.mem_rdata;
            else       cpu_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data stay parked on the latched request; mem_en alone qualifies them.
  assign cpu_ack        = (state_q == RESP) & ~gid_q;
  assign bus.cpu_ack    = cpu_ack;
  assign bus.ext_ack    = (state_q == RESP) & gid_q;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.mem_en     = (state_q == ISSUE);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = gid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), a transaction-level model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]    rst_a, cpu_req_a, cpu_we_a, ext_req_a, ext_we_a;
  logic [AW-1:0] cpu_addr_a [2];
  logic [AW-1:0] ext_addr_a [2];
  logic [DW-1:0] cpu_wdata_a [2];
  logic [DW-1:0] ext_wdata_a [2];
  logic [1:0]    cpu_ack_a, ext_ack_a, cpu_stall_a, mem_en_a, mem_we_a, busy_a, gid_a;
  logic [AW-1:0] mem_addr_a [2];
  logic [DW-1:0] mem_wdata_a [2];
  logic [DW-1:0] cpu_rdata_a [2];
  logic [DW-1:0] ext_rdata_a [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Contents of memory words never written.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 1 : 3;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    logic [DW-1:0] mrd;

    assign bus.cpu_req   = cpu_req_a[gi];
    assign bus.cpu_we    = cpu_we_a[gi];
    assign bus.cpu_addr  = cpu_addr_a[gi];
    assign bus.cpu_wdata = cpu_wdata_a[gi];
    assign bus.ext_req   = ext_req_a[gi];
    assign bus.ext_we    = ext_we_a[gi];
    assign bus.ext_addr  = ext_addr_a[gi];
    assign bus.ext_wdata = ext_wdata_a[gi];
    assign bus.mem_rdata = mrd;
    assign cpu_ack_a[gi]   = bus.cpu_ack;
    assign ext_ack_a[gi]   = bus.ext_ack;
    assign cpu_stall_a[gi] = bus.cpu_stall;
    assign mem_en_a[gi]    = bus.mem_en;
    assign mem_we_a[gi]    = bus.mem_we;
    assign busy_a[gi]      = bus.busy;
    assign gid_a[gi]       = bus.grant_id;
    assign mem_addr_a[gi]  = bus.mem_addr;
    assign mem_wdata_a[gi] = bus.mem_wdata;
    assign cpu_rdata_a[gi] = bus.cpu_rdata;
    assign ext_rdata_a[gi] = bus.ext_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L)) dut (
      .clk (clk),
      .rst (rst_a[gi]),
      .bus (bus)
    );

    // Memory: data valid only in the cycle MEM_LAT after the issue cycle, junk otherwise.
    logic [31:0] bmem [logic [31:0]];
    int          iss   = -100;
    logic [31:0] paddr = '0;
    always @(negedge clk) begin
      if (bus.mem_en) begin
        iss   = cyc;
        paddr = bus.mem_addr;
        if (bus.mem_we) bmem[bus.mem_addr] = bus.mem_wdata;
      end
      if (cyc == iss + L) mrd = bmem.exists(paddr) ? bmem[paddr] : dflt(paddr);
      else                mrd = 32'hBAD0_0000 ^ 32'(cyc);
    end

    // Transaction model: a request latched in cycle s owns cycles s+1..s+L+2.
    bit          act = 0, own = 0, mwe = 0, gid = 0, last = 1;
    int          s = 0;
    logic [31:0] maddr = '0, mwd = '0, crd = '0, erd = '0;
    logic [31:0] mmem [logic [31:0]];
    always @(negedge clk) begin
      int d;
      bit e_en, e_busy, e_cack, e_eack;
      if (!rst_a[gi]) begin
        act = 0; own = 0; mwe = 0; gid = 0; last = 1;
        maddr = '0; mwd = '0; crd = '0; erd = '0;
      end
      d = cyc - s;
      if (act && d == 1 && mwe) mmem[maddr] = mwd;
      if (act && d == L + 2 && !mwe) begin
        if (own) erd = mmem.exists(maddr) ? mmem[maddr] : dflt(maddr);
        else     crd = mmem.exists(maddr) ? mmem[maddr] : dflt(maddr);
      end
      e_en   = act && d == 1;
      e_busy = act && d >= 1 && d <= L + 2;
      e_cack = act && d == L + 2 && !own;
      e_eack = act && d == L + 2 && own;
      chk($sformatf("i%0d.mem_en", gi),    32'(mem_en_a[gi]),    32'(e_en));
      chk($sformatf("i%0d.busy", gi),      32'(busy_a[gi]),      32'(e_busy));
      chk($sformatf("i%0d.cpu_ack", gi),   32'(cpu_ack_a[gi]),   32'(e_cack));
      chk($sformatf("i%0d.ext_ack", gi),   32'(ext_ack_a[gi]),   32'(e_eack));
      chk($sformatf("i%0d.cpu_stall", gi), 32'(cpu_stall_a[gi]), 32'(cpu_req_a[gi] & ~e_cack));
      chk($sformatf("i%0d.grant_id", gi),  32'(gid_a[gi]),       32'(gid));
      chk($sformatf("i%0d.mem_we", gi),    32'(mem_we_a[gi]),    32'(mwe));
      chk($sformatf("i%0d.mem_addr", gi),  mem_addr_a[gi],       maddr);
      chk($sformatf("i%0d.mem_wdata", gi), mem_wdata_a[gi],      mwd);
      chk($sformatf("i%0d.cpu_rdata", gi), cpu_rdata_a[gi],      crd);
      chk($sformatf("i%0d.ext_rdata", gi), ext_rdata_a[gi],      erd);
      if (rst_a[gi] && (!act || d >= L + 3) && (cpu_req_a[gi] || ext_req_a[gi])) begin
`ifdef MEM_ARB_RR_EN
        own = (cpu_req_a[gi] && ext_req_a[gi]) ? !last : ext_req_a[gi];
`else
        own = ext_req_a[gi];
`endif
        last  = own;
        act   = 1;
        s     = cyc;
        gid   = own;
        mwe   = own ? ext_we_a[gi]    : cpu_we_a[gi];
        maddr = own ? ext_addr_a[gi]  : cpu_addr_a[gi];
        mwd   = own ? ext_wdata_a[gi] : cpu_wdata_a[gi];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles from the cycle the requests were raised (cycle 0), logging one bit per cycle.
  // Each requester drops its req in the cycle after its ack; cpu_req also drops at cycle cpu_drop_at.
  task automatic observe(input int k, input int n, input int cpu_drop_at,
                         output logic [15:0] en_l, output logic [15:0] cack_l,
                         output logic [15:0] eack_l, output logic [15:0] stall_l,
                         output logic [15:0] busy_l, output logic [15:0] gid_l,
                         output logic we1, output logic [31:0] addr1, output logic [31:0] wdata1);
    en_l = '0; cack_l = '0; eack_l = '0; stall_l = '0; busy_l = '0; gid_l = '0;
    we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_l[i]    = mem_en_a[k];
      cack_l[i]  = cpu_ack_a[k];
      eack_l[i]  = ext_ack_a[k];
      stall_l[i] = cpu_stall_a[k];
      busy_l[i]  = busy_a[k];
      gid_l[i]   = gid_a[k];
      if (i == 1) begin
        we1 = mem_we_a[k]; addr1 = mem_addr_a[k]; wdata1 = mem_wdata_a[k];
      end
      step();
      if (cack_l[i] || i + 1 == cpu_drop_at) cpu_req_a[k] = 1'b0;
      if (eack_l[i]) ext_req_a[k] = 1'b0;
    end
  endtask

  task automatic mid_reset(input int k, input int edges, input logic [31:0] a);
    logic [15:0] en_l, cack_l, eack_l, stall_l, busy_l, gid_l;
    logic        we1;
    logic [31:0] addr1, wdata1;
    int          L;
    L = (k == 0) ? 1 : 3;
    cpu_we_a[k] = 1'b0; cpu_addr_a[k] = a; cpu_req_a[k] = 1'b1;
    repeat (edges) step();
    #1;
    rst_a[k] = 1'b0;
    cpu_req_a[k] = 1'b0;
    #1;
    chk($sformatf("i%0d.rst_mid%0d mem_en", k, edges),  32'(mem_en_a[k]),  32'd0);
    chk($sformatf("i%0d.rst_mid%0d busy", k, edges),    32'(busy_a[k]),    32'd0);
    chk($sformatf("i%0d.rst_mid%0d cpu_ack", k, edges), 32'(cpu_ack_a[k]), 32'd0);
    repeat (2) step();
    rst_a[k] = 1'b1;
    observe(k, L + 4, -1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
    chk($sformatf("i%0d.rst_mid%0d late ack", k, edges), 32'(cack_l), 32'd0);
    chk($sformatf("i%0d.rst_mid%0d late en", k, edges),  32'(en_l),   32'd0);
  endtask

  task automatic run_script(input int k);
    logic [15:0] en_l, cack_l, eack_l, stall_l, busy_l, gid_l;
    logic        we1;
    logic [31:0] addr1, wdata1;
    logic [15:0] x_cack, x_eack;
    logic        x_gid1, x_gid2;
    int          L;
    L = (k == 0) ? 1 : 3;

    rst_a[k] = 1'b0;
    repeat (3) step();
    chk($sformatf("i%0d.reset busy", k),      32'(busy_a[k]),    32'd0);
    chk($sformatf("i%0d.reset mem_en", k),    32'(mem_en_a[k]),  32'd0);
    chk($sformatf("i%0d.reset grant_id", k),  32'(gid_a[k]),     32'd0);
    chk($sformatf("i%0d.reset cpu_rdata", k), cpu_rdata_a[k],    32'd0);
    rst_a[k] = 1'b1;
    step();

    // CPU read of 0x10
    cpu_we_a[k] = 1'b0; cpu_addr_a[k] = 32'h10; cpu_req_a[k] = 1'b1;
    observe(k, L + 5, -1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
    chk($sformatf("i%0d.rd en cycles", k),    32'(en_l),    32'h2);
    chk($sformatf("i%0d.rd ack cycle", k),    32'(cack_l),  32'(1 << (L + 2)));
    chk($sformatf("i%0d.rd stall", k),        32'(stall_l), 32'((1 << (L + 2)) - 1));
    chk($sformatf("i%0d.rd busy", k),         32'(busy_l),  32'(((1 << (L + 3)) - 1) ^ 1));
    chk($sformatf("i%0d.rd cpu_rdata", k),    cpu_rdata_a[k], 32'hDEADBEEF);

    // External read, write, read-back
    ext_we_a[k] = 1'b0; ext_addr_a[k] = 32'h30; ext_req_a[k] = 1'b1;
    observe(k, L + 4, -1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
    chk($sformatf("i%0d.erd ext_rdata", k),   ext_rdata_a[k], 32'h5A5A_0030);
    ext_we_a[k] = 1'b1; ext_addr_a[k] = 32'h20; ext_wdata_a[k] = 32'h12345678; ext_req_a[k] = 1'b1;
    observe(k, L + 4, -1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
    chk($sformatf("i%0d.ewr en cycles", k),   32'(en_l),    32'h2);
    chk($sformatf("i%0d.ewr mem_we", k),      32'(we1),     32'd1);
    chk($sformatf("i%0d.ewr mem_addr", k),    addr1,        32'h20);
    chk($sformatf("i%0d.ewr mem_wdata", k),   wdata1,       32'h12345678);
    chk($sformatf("i%0d.ewr ack cycle", k),   32'(eack_l),  32'(1 << (L + 2)));
    chk($sformatf("i%0d.ewr ext_rdata", k),   ext_rdata_a[k], 32'h5A5A_0030);
    ext_we_a[k] = 1'b0; ext_req_a[k] = 1'b1;
    observe(k, L + 4, -1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
    chk($sformatf("i%0d.erb ext_rdata", k),   ext_rdata_a[k], 32'h12345678);

    // Two concurrent pairs, each held through its ack
`ifdef MEM_ARB_RR_EN
    x_cack = 16'(1 << (L + 2)); x_eack = 16'(1 << (2 * L + 5)); x_gid1 = 1'b0; x_gid2 = 1'b1;
`else
    x_eack = 16'(1 << (L + 2)); x_cack = 16'(1 << (2 * L + 5)); x_gid1 = 1'b1; x_gid2 = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      cpu_we_a[k] = 1'b0; cpu_addr_a[k] = 32'h40 + 32'(8 * p); cpu_req_a[k] = 1'b1;
      ext_we_a[k] = 1'b0; ext_addr_a[k] = 32'h44 + 32'(8 * p); ext_req_a[k] = 1'b1;
      observe(k, 2 * L + 7, -1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
      chk($sformatf("i%0d.pair%0d cpu_ack", k, p),  32'(cack_l),          32'(x_cack));
      chk($sformatf("i%0d.pair%0d ext_ack", k, p),  32'(eack_l),          32'(x_eack));
      chk($sformatf("i%0d.pair%0d grant1", k, p),   32'(gid_l[1]),        32'(x_gid1));
      chk($sformatf("i%0d.pair%0d grant2", k, p),   32'(gid_l[L + 4]),    32'(x_gid2));
      chk($sformatf("i%0d.pair%0d cpu_rdata", k, p), cpu_rdata_a[k], 32'h5A5A_0040 + 32'(8 * p));
      chk($sformatf("i%0d.pair%0d ext_rdata", k, p), ext_rdata_a[k], 32'h5A5A_0044 + 32'(8 * p));
    end

    // CPU drops its request during ISSUE
    cpu_we_a[k] = 1'b0; cpu_addr_a[k] = 32'h50; cpu_req_a[k] = 1'b1;
    observe(k, L + 7, 1, en_l, cack_l, eack_l, stall_l, busy_l, gid_l, we1, addr1, wdata1);
    chk($sformatf("i%0d.drop ack", k),        32'(cack_l),  32'(1 << (L + 2)));
    chk($sformatf("i%0d.drop en", k),         32'(en_l),    32'h2);
    chk($sformatf("i%0d.drop busy", k),       32'(busy_l),  32'(((1 << (L + 3)) - 1) ^ 1));
    chk($sformatf("i%0d.drop cpu_rdata", k),  cpu_rdata_a[k], 32'h5A5A_0050);

    // Reset during ISSUE, then during WAIT
    mid_reset(k, 1, 32'h60);
    chk($sformatf("i%0d.post-reset cpu_rdata", k), cpu_rdata_a[k], 32'd0);
    mid_reset(k, 2, 32'h64);
  endtask

  initial begin
    rst_a = 2'b00; cpu_req_a = '0; cpu_we_a = '0; ext_req_a = '0; ext_we_a = '0;
    for (int k = 0; k < 2; k++) begin
      cpu_addr_a[k] = '0; ext_addr_a[k] = '0; cpu_wdata_a[k] = '0; ext_wdata_a[k] = '0;
    end
    step();
    for (int k = 0; k < 2; k++) run_script(k);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
